// File: rtl/bandai2003_pkg.sv
// Shared constants for the Bandai 2003 mapper unlock host.
// Contents: unlock address pair, bank register addresses, default
// acknowledge word, frame length, top-level FSM state codes and the
// serial receiver phase codes, plus a bank-address helper.
// Optional feature macro used by the importing files: BANK_INIT_EN.
package bandai2003_pkg;

    // Two-step unlock sequence presented on the cartridge address byte
    localparam logic [7:0] UNLOCK_ADDR_A = 8'h5A;
    localparam logic [7:0] UNLOCK_ADDR_B = 8'hA5;

    // Bank registers written by the optional init sequencer
    localparam logic [7:0] BANK_ADDR_0 = 8'hC0;
    localparam logic [7:0] BANK_ADDR_1 = 8'hC1;
    localparam logic [7:0] BANK_ADDR_2 = 8'hC2;
    localparam logic [7:0] BANK_ADDR_3 = 8'hC3;

    // Payload a compliant mapper returns after unlocking
    localparam logic [15:0] ACK_WORD = 16'h28A0;

    // Frame = start bit + payload + tail bit
    localparam int unsigned FRAME_LEN = 18;
    localparam int unsigned DATA_BITS = FRAME_LEN - 2;

    // Top-level FSM states (HUNT/DATA/TAIL live in the receiver as RX)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACK    = 3'd1;
    localparam logic [2:0] ST_NAK    = 3'd2;
    localparam logic [2:0] ST_RX     = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;
    localparam logic [2:0] ST_SETUP  = 3'd5;
    localparam logic [2:0] ST_STROBE = 3'd6;
    localparam logic [2:0] ST_HOLD   = 3'd7;

    // Serial receiver phases
    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_HUNT = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] RX_TAIL = 2'd3;

    // Map a write index 0..3 onto bank register C0..C3
    function automatic logic [7:0] bank_addr(input logic [1:0] idx);
        logic [7:0] a;
        case (idx)
            2'd0:    a = BANK_ADDR_0;
            2'd1:    a = BANK_ADDR_1;
            2'd2:    a = BANK_ADDR_2;
            2'd3:    a = BANK_ADDR_3;
            default: a = BANK_ADDR_0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bandai_serial_rx.sv
// Acknowledge-frame receiver: hunts for the start bit with a timeout,
// shifts in 16 payload bits LSB first, then checks the tail bit.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         begin hunting on the next edge (ignored unless idle)
//   si_i            mapper serial output
//   done_o          this edge completes the frame (tail or timeout)
//   ok_o            with done_o: tail bit was 0
//   word_o          received payload (0 after a timeout)
// done_o/ok_o are combinational so the host can act on the very edge the
// tail is sampled; the host registers everything it drives off-chip.
module bandai_serial_rx
    import bandai2003_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        si_i,
    output logic        done_o,
    output logic        ok_o,
    output logic [15:0] word_o
);

    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [3:0] LAST_BIT_C = 4'(DATA_BITS - 1);

    logic [1:0]  phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] word_q, word_d;

    // Receiver next-state: hunt countdown, LSB-first shift, tail sample
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        word_d  = word_q;
        case (phase_q)
            RX_IDLE: begin
                if (start_i) begin
                    phase_d = RX_HUNT;
                    cnt_d   = TIMEOUT_C;
                    bit_d   = 4'd0;
                    word_d  = 16'h0000;
                end else begin
                    phase_d = RX_IDLE;
                end
            end
            RX_HUNT: begin
                if (!si_i) begin
                    phase_d = RX_DATA;
                    bit_d   = 4'd0;
                end else if (cnt_q <= 8'd1) begin
                    // countdown reaches zero on this sample
                    phase_d = RX_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RX_DATA: begin
                word_d = {si_i, word_q[15:1]};
                if (bit_q == LAST_BIT_C) begin
                    phase_d = RX_TAIL;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            RX_TAIL: begin
                phase_d = RX_IDLE;
            end
            default: begin
                phase_d = RX_IDLE;
            end
        endcase
    end

    // Completion and validity of the frame on the current edge
    always_comb begin
        done_o = ((phase_q == RX_HUNT) && si_i && (cnt_q <= 8'd1)) ||
                 (phase_q == RX_TAIL);
        ok_o   = (phase_q == RX_TAIL) && !si_i;
    end

    assign word_o = word_q;

    // Receiver state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= RX_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 4'd0;
            word_q  <= 16'h0000;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: rtl/bandai_unlock_host.sv
// Console-side unlock initiator for the Bandai 2003 mapper.
// Presents 0x5A then 0xA5 on ADDR, receives the 18-bit acknowledge frame
// on SI and reports DONE/OK/WORD.
// Ports:
//   CLK, RSTn            clock, asynchronous active-low reset
//   START                one-cycle request, only honoured in idle
//   BUSY, DONE           run in progress / one-cycle completion pulse
//   OK, WORD             result, valid with DONE and held
//   SI                   mapper serial output
//   ADDR, CEn/SSn/OEn/WEn  cartridge address byte and bus strobes
// Optional (macro BANK_INIT_EN): BANK_DATA in, DQ/DQ_OE out; after a good
// acknowledge, writes BANK_DATA bytes to registers C0..C3.
module bandai_unlock_host
    import bandai2003_pkg::*;
#(
    parameter int          TIMEOUT = 32,
    parameter logic [15:0] EXPECT  = ACK_WORD
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        OK,
    output logic [15:0] WORD,
    input  logic        SI,
    output logic [7:0]  ADDR,
    output logic        CEn,
    output logic        SSn,
    output logic        OEn,
`ifdef BANK_INIT_EN
    output logic        WEn,
    input  logic [31:0] BANK_DATA,
    output logic [7:0]  DQ,
    output logic        DQ_OE
`else
    output logic        WEn
`endif
);

    logic [2:0]  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        ok_pend_q, ok_pend_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  addr_q, addr_d;
    logic        cen_q, oen_q;
    logic        ssn_q, ssn_d;
    logic        wen_q, wen_d;
`ifdef BANK_INIT_EN
    logic [7:0]  dq_q, dq_d;
    logic        dq_oe_q, dq_oe_d;
`endif

    logic        rx_start_s;
    logic        rx_done_s;
    logic        rx_ok_s;
    logic [15:0] rx_word_s;
    logic        match_s;

    // The receiver is armed while NAK is on the bus so it hunts from the next edge
    assign rx_start_s = (state_q == ST_NAK);

    bandai_serial_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk_i   (CLK),
        .rst_ni  (RSTn),
        .start_i (rx_start_s),
        .si_i    (SI),
        .done_o  (rx_done_s),
        .ok_o    (rx_ok_s),
        .word_o  (rx_word_s)
    );

    assign match_s = rx_ok_s && (rx_word_s == EXPECT);

    // Control FSM next-state and result bookkeeping
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ok_pend_d = ok_pend_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ok_d      = ok_q;
        word_d    = word_q;
        case (state_q)
            ST_IDLE: begin
                // a START coinciding with the DONE pulse is not taken
                if (START && !done_q) begin
                    state_d = ST_ACK;
                    busy_d  = 1'b1;
                    ok_d    = 1'b0;
                    word_d  = 16'h0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_NAK;
            ST_NAK:  state_d = ST_RX;
            ST_RX: begin
                if (rx_done_s) begin
                    ok_pend_d = match_s;
                    idx_d     = 2'd0;
`ifdef BANK_INIT_EN
                    state_d   = match_s ? ST_SETUP : ST_FIN;
`else
                    state_d   = ST_FIN;
`endif
                end else begin
                    state_d = ST_RX;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_SETUP;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ok_d    = ok_pend_q;
                word_d  = rx_word_s;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Bus drive decoded from the next state so pins change with the state
    always_comb begin
        addr_d = 8'h00;
        ssn_d  = 1'b1;
        wen_d  = 1'b1;
`ifdef BANK_INIT_EN
        dq_d    = 8'h00;
        dq_oe_d = 1'b0;
`endif
        case (state_d)
            ST_ACK: addr_d = UNLOCK_ADDR_A;
            ST_NAK: addr_d = UNLOCK_ADDR_B;
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                addr_d = bank_addr(idx_d);
                ssn_d  = 1'b0;
                wen_d  = (state_d != ST_STROBE);
`ifdef BANK_INIT_EN
                dq_d    = BANK_DATA[{idx_d, 3'b000} +: 8];
                dq_oe_d = 1'b1;
`endif
            end
            default: addr_d = 8'h00;
        endcase
    end

    // State and output registers; strobes fall back high asynchronously
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            ok_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            word_q    <= 16'h0000;
            addr_q    <= 8'h00;
            cen_q     <= 1'b1;
            oen_q     <= 1'b1;
            ssn_q     <= 1'b1;
            wen_q     <= 1'b1;
`ifdef BANK_INIT_EN
            dq_q      <= 8'h00;
            dq_oe_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ok_pend_q <= ok_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            cen_q     <= 1'b1;
            oen_q     <= 1'b1;
            ssn_q     <= ssn_d;
            wen_q     <= wen_d;
`ifdef BANK_INIT_EN
            dq_q      <= dq_d;
            dq_oe_q   <= dq_oe_d;
`endif
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign OK   = ok_q;
    assign WORD = word_q;
    assign ADDR = addr_q;
    assign CEn  = cen_q;
    assign OEn  = oen_q;
    assign SSn  = ssn_q;
    assign WEn  = wen_q;
`ifdef BANK_INIT_EN
    assign DQ    = dq_q;
    assign DQ_OE = dq_oe_q;
`endif

endmodule

// File: tb/tb_bandai_unlock_host.sv
// Directed bench for bandai_unlock_host with a behavioural mapper model.
module tb_bandai_unlock_host;

`ifdef BANK_INIT_EN
    localparam bit BANK_BUILD = 1'b1;
    localparam int GOOD_DONE  = 33;
`else
    localparam bit BANK_BUILD = 1'b0;
    localparam int GOOD_DONE  = 21;
`endif
    localparam int BAD_DONE     = 21;
    localparam int TIMEOUT_DONE = 35;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        START;
    logic        BUSY, DONE, OK;
    logic [15:0] WORD;
    logic        SI;
    logic [7:0]  ADDR;
    logic        CEn, SSn, OEn, WEn;
`ifdef BANK_INIT_EN
    logic [31:0] BANK_DATA;
    logic [7:0]  DQ;
    logic        DQ_OE;
`endif

    int vectors = 0;
    int miscompares = 0;

    // mapper model state
    int          m_state;
    int          m_cnt;
    logic        m_si;
    logic        m_prev_wen;
    logic [7:0]  m_regs [0:3];
    logic [15:0] m_payload;
    logic        m_tail;

    logic [7:0]  addr_seen [0:3];
    logic        strobe_bad;
    int          done_at;

    assign SI = m_si;

    always #5 CLK = ~CLK;

    bandai_unlock_host #(
        .TIMEOUT (32),
        .EXPECT  (16'h28A0)
    ) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .START (START),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OK    (OK),
        .WORD  (WORD),
        .SI    (SI),
        .ADDR  (ADDR),
        .CEn   (CEn),
        .SSn   (SSn),
        .OEn   (OEn),
`ifdef BANK_INIT_EN
        .WEn       (WEn),
        .BANK_DATA (BANK_DATA),
        .DQ        (DQ),
        .DQ_OE     (DQ_OE)
`else
        .WEn   (WEn)
`endif
    );

    // Mapper: 5A then A5 on consecutive edges unlocks it and starts the frame
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m_state    <= 0;
            m_cnt      <= 0;
            m_si       <= 1'b1;
            m_prev_wen <= 1'b1;
            for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
        end else begin
            m_prev_wen <= WEn;
            case (m_state)
                0: if (ADDR == 8'h5A) m_state <= 1;
                1: begin
                    if (ADDR == 8'hA5) begin
                        m_state <= 2;
                        m_si    <= 1'b0;
                        m_cnt   <= 0;
                    end else if (ADDR != 8'h5A) begin
                        m_state <= 0;
                    end
                end
                2: begin
                    if (m_cnt < 16) begin
                        m_si  <= m_payload[m_cnt];
                        m_cnt <= m_cnt + 1;
                    end else if (m_cnt == 16) begin
                        m_si  <= m_tail;
                        m_cnt <= 17;
                    end else begin
                        m_si    <= 1'b1;
                        m_state <= 3;
                    end
                end
                default: begin
`ifdef BANK_INIT_EN
                    if (!m_prev_wen && WEn && !SSn && DQ_OE && ADDR[7:2] == 6'b110000)
                        m_regs[ADDR[1:0]] <= DQ;
`endif
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        START = 1'b0;
        tick();
        tick();
        RSTn = 1'b1;
    endtask

    // Pulse START (accepted at edge 0) and wait a bounded time for DONE
    task automatic run(input int limit, output int d_at);
        d_at = -1;
        strobe_bad = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        addr_seen[0] = ADDR;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (n < 4) addr_seen[n] = ADDR;
            if (CEn !== 1'b1 || OEn !== 1'b1) strobe_bad = 1'b1;
            if (!BANK_BUILD && (SSn !== 1'b1 || WEn !== 1'b1)) strobe_bad = 1'b1;
            if (DONE === 1'b1) begin
                d_at = n;
                break;
            end
        end
    endtask

    initial begin
        int busy_first;
        int done_cnt;
        int done1;
        int done2;
        int rise2;
        RSTn = 1'b0;
        START = 1'b0;
        m_payload = 16'h28A0;
        m_tail = 1'b0;
`ifdef BANK_INIT_EN
        BANK_DATA = 32'h04030201;
`endif

        // reset state
        do_reset();
        check("rst_addr", {24'h0, ADDR}, 32'h00);
        check("rst_strobes", {28'h0, CEn, SSn, OEn, WEn}, 32'hF);
        check("rst_flags", {29'h0, BUSY, DONE, OK}, 32'h0);
        check("rst_word", {16'h0, WORD}, 32'h0);

        // compliant mapper
        run(60, done_at);
        check("good_addr0", {24'h0, addr_seen[0]}, 32'h5A);
        check("good_addr1", {24'h0, addr_seen[1]}, 32'hA5);
        check("good_addr2", {24'h0, addr_seen[2]}, 32'h00);
        check("good_done_edge", done_at, GOOD_DONE);
        check("good_ok", {31'h0, OK}, 32'h1);
        check("good_word", {16'h0, WORD}, 32'h28A0);
        check("good_busy_low", {31'h0, BUSY}, 32'h0);
        check("good_strobes", {31'h0, strobe_bad}, 32'h0);
`ifdef BANK_INIT_EN
        check("bank_c0", {24'h0, m_regs[0]}, 32'h01);
        check("bank_c1", {24'h0, m_regs[1]}, 32'h02);
        check("bank_c2", {24'h0, m_regs[2]}, 32'h03);
        check("bank_c3", {24'h0, m_regs[3]}, 32'h04);
        check("bank_dq_idle", {23'h0, DQ_OE, DQ}, 32'h0);
`endif
        tick();
        check("done_pulse_one", {31'h0, DONE}, 32'h0);
        check("ok_held", {31'h0, OK}, 32'h1);

        // second run, mapper already unlocked: timeout
        run(60, done_at);
        check("to_done_edge", done_at, TIMEOUT_DONE);
        check("to_ok", {31'h0, OK}, 32'h0);
        check("to_word", {16'h0, WORD}, 32'h0);

        // START in the DONE cycle is ignored
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_on_done_busy", {31'h0, BUSY}, 32'h0);
        tick();
        check("start_on_done_addr", {24'h0, ADDR}, 32'h00);

        // corrupted payload
        do_reset();
        m_payload = 16'h28A1;
        run(60, done_at);
        check("bad_word_done", done_at, BAD_DONE);
        check("bad_word_ok", {31'h0, OK}, 32'h0);
        check("bad_word_word", {16'h0, WORD}, 32'h28A1);

        // tail bit forced high
        do_reset();
        m_payload = 16'h28A0;
        m_tail = 1'b1;
        run(60, done_at);
        check("bad_tail_done", done_at, BAD_DONE);
        check("bad_tail_ok", {31'h0, OK}, 32'h0);
        m_tail = 1'b0;

        // reset during DATA
        do_reset();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (9) tick();
        check("mid_busy", {31'h0, BUSY}, 32'h1);
        RSTn = 1'b0;
        #1;
        check("mid_rst_flags", {29'h0, BUSY, DONE, OK}, 32'h0);
        check("mid_rst_addr", {24'h0, ADDR}, 32'h00);
        done_cnt = 0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (DONE !== 1'b0) done_cnt++;
        end
        RSTn = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (DONE !== 1'b0) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 0);
        run(60, done_at);
        check("after_rst_done", done_at, GOOD_DONE);
        check("after_rst_ok", {31'h0, OK}, 32'h1);
        check("after_rst_word", {16'h0, WORD}, 32'h28A0);

        // START held high: one run per idle visit
        do_reset();
        busy_first = 0;
        done_cnt = 0;
        done1 = -1;
        done2 = -1;
        rise2 = -1;
        START = 1'b1;
        for (int n = 0; n <= GOOD_DONE + 2 + TIMEOUT_DONE + 1; n++) begin
            tick();
            if (done1 < 0 && BUSY === 1'b1) busy_first++;
            if (DONE === 1'b1) begin
                done_cnt++;
                if (done1 < 0) done1 = n;
                else if (done2 < 0) done2 = n;
            end
            if (done1 >= 0 && n > done1 && rise2 < 0 && BUSY === 1'b1) rise2 = n;
        end
        START = 1'b0;
        check("held_busy_cycles", busy_first, GOOD_DONE);
        check("held_done1", done1, GOOD_DONE);
        check("held_rise2", rise2, GOOD_DONE + 2);
        check("held_done2", done2, GOOD_DONE + 2 + TIMEOUT_DONE);
        check("held_done_count", done_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
